multicycle_ctrl_fsm: RTL and testbench

Multicycle control unit for the ARM-subset processor. It replaces the single-cycle main and ALU decoders with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, so one ALU and one unified memory can be shared. It adds a memory wait-state handshake with a timeout, a parametrised ALU control width, and an optional CMP instruction. It sits between the instruction register and the datapath muxes; its raw PCS, RegW, MemW and FlagW outputs feed the existing conditional logic.

---
 rtl/multicycle_ctrl_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 47 ++++
 rtl/multicycle_alu_dec.sv | 63 ++++++
 rtl/multicycle_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared types and encodings for the multicycle control unit:
//               state enum, ALU operation codes, DP command codes and the
//               ALUSrcB / ResultSrc mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWR    = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // ALU operation codes (zero-extended to the configured ALUControl width)
  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_ORR = 3'b011;
  localparam logic [2:0] C_ALU_MOV = 3'b100;

  // Data-processing command field Funct[4:1]
  localparam logic [3:0] C_CMD_AND = 4'b0000;
  localparam logic [3:0] C_CMD_SUB = 4'b0010;
  localparam logic [3:0] C_CMD_ADD = 4'b0100;
  localparam logic [3:0] C_CMD_CMP = 4'b1010;
  localparam logic [3:0] C_CMD_ORR = 4'b1100;
  localparam logic [3:0] C_CMD_MOV = 4'b1101;

  // ALUSrcB mux encodings
  localparam logic [1:0] C_SRCB_REG  = 2'b00;
  localparam logic [1:0] C_SRCB_IMM  = 2'b01;
  localparam logic [1:0] C_SRCB_FOUR = 2'b10;

  // ResultSrc mux encodings
  localparam logic [1:0] C_RES_ALUOUT = 2'b00;
  localparam logic [1:0] C_RES_DATA   = 2'b01;
  localparam logic [1:0] C_RES_ALU    = 2'b10;

  // States that wait on mem_ready and therefore run the timeout counter
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm_if
// Description : Bundle between instruction register / memory handshake and
//               the multicycle controller. The master side supplies the
//               instruction fields and mem_ready; the slave (controller)
//               drives all datapath controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
  parameter int ALUCTRL_W = 3
);
  logic [1:0]           Op;
  logic [5:0]           Funct;
  logic [3:0]           Rd;
  logic                 mem_ready;

  logic                 IRWrite;
  logic                 AdrSrc;
  logic                 ALUSrcA;
  logic                 NextPC;
  logic                 RegW;
  logic                 MemW;
  logic                 Branch;
  logic                 PCS;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ResultSrc;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [1:0]           FlagW;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal;
  logic                 mem_err;

  modport master (
    output Op, Funct, Rd, mem_ready,
    input  IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, PCS,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl, illegal, mem_err
  );

  modport slave (
    input  Op, Funct, Rd, mem_ready,
    output IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, PCS,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW, ALUControl, illegal, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_alu_dec.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_alu_dec
// Description : Combinational ALU decoder. Maps the DP command Funct[4:1]
//               to an ALU operation and flag-write enables while active,
//               and flags unsupported commands regardless of active.
//               Optional macro: MULTICYCLE_CTRL_CMP_EN adds CMP (1010).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_alu_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [4:0]           i_funct,
  input  logic                 i_active,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic [1:0]           o_flag_w,
  output logic                 o_is_cmp,
  output logic                 o_unsupported
);

  logic [2:0] w_code;
  logic       w_known;
  logic       w_cmp;

  // Command lookup, independent of whether an EXECUTE state is active
  always_comb begin
    w_code  = C_ALU_ADD;
    w_known = 1'b1;
    w_cmp   = 1'b0;
    case (i_funct[4:1])
      C_CMD_MOV: w_code = C_ALU_MOV;
      C_CMD_ADD: w_code = C_ALU_ADD;
      C_CMD_SUB: w_code = C_ALU_SUB;
      C_CMD_AND: w_code = C_ALU_AND;
      C_CMD_ORR: w_code = C_ALU_ORR;
`ifdef MULTICYCLE_CTRL_CMP_EN
      C_CMD_CMP: begin
        w_code = C_ALU_SUB;
        w_cmp  = 1'b1;
      end
`endif
      default:   w_known = 1'b0;
    endcase
  end

  // Drive ALU controls only in EXECUTE; ADD and no flag writes otherwise
  always_comb begin
    o_alu_control = '0;
    o_flag_w      = 2'b00;
    if (i_active) begin
      o_alu_control = ALUCTRL_W'(w_code);
      o_flag_w[1]   = i_funct[0];
      o_flag_w[0]   = i_funct[0] & ((w_code == C_ALU_ADD) | (w_code == C_ALU_SUB));
    end
  end

  assign o_is_cmp      = w_cmp;
  assign o_unsupported = ~w_known;

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_fsm
// Description : Moore control unit for the multicycle ARM-subset datapath.
//               Sequences FETCH/DECODE/EXECUTE/MEM/WB with a mem_ready
//               wait-state handshake and a TIMEOUT abort (mem_err).
//               Optional macro: MULTICYCLE_CTRL_CMP_EN enables CMP.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic                 w_wait;
  logic                 w_timeout;
  logic                 w_illegal;
  logic                 w_exec;
  logic                 w_regw;
  logic                 w_branch;
  logic [ALUCTRL_W-1:0] w_alu_ctrl;
  logic [1:0]           w_flag_w;
  logic                 w_is_cmp;
  logic                 w_unsup;

  assign w_wait    = is_wait_state(r_state);
  // mem_ready in the same cycle beats the timeout
  assign w_timeout = w_wait & ~bus.mem_ready & (r_wait_cnt == CNT_W'(TIMEOUT));
  assign w_exec    = (r_state == S_EXECUTER) | (r_state == S_EXECUTEI);

  multicycle_alu_dec #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_dec (
    .i_funct       (bus.Funct[4:0]),
    .i_active      (w_exec),
    .o_alu_control (w_alu_ctrl),
    .o_flag_w      (w_flag_w),
    .o_is_cmp      (w_is_cmp),
    .o_unsupported (w_unsup)
  );

  // Next-state selection and the DECODE-time illegal pulse
  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.mem_ready)  w_next = S_DECODE;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_DECODE: begin
        case (bus.Op)
          2'b00: begin
            if (w_unsup) begin
              w_next    = S_FETCH;
              w_illegal = 1'b1;
            end else if (bus.Funct[5]) begin
              w_next = S_EXECUTEI;
            end else begin
              w_next = S_EXECUTER;
            end
          end
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.mem_ready || w_timeout) w_next = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: w_next = w_is_cmp ? S_FETCH : S_ALUWB;
      default: w_next = S_FETCH;
    endcase
  end

  // State register and wait counter; counter runs only while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_wait && !bus.mem_ready && !w_timeout) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      else                                        r_wait_cnt <= '0;
    end
  end

  // Moore output decode; strobes suppressed on the timeout cycle
  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.NextPC    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.MemW      = 1'b0;
    bus.ALUSrcB   = C_SRCB_REG;
    bus.ResultSrc = C_RES_ALUOUT;
    w_regw        = 1'b0;
    w_branch      = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.IRWrite   = bus.mem_ready;
        bus.NextPC    = bus.mem_ready;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = C_SRCB_FOUR;
        bus.ResultSrc = C_RES_ALU;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = C_SRCB_FOUR;
        bus.ResultSrc = C_RES_ALU;
      end
      S_MEMADR: bus.ALUSrcB = C_SRCB_IMM;
      S_MEMRD:  bus.AdrSrc  = 1'b1;
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = ~w_timeout;
      end
      S_MEMWB: begin
        bus.ResultSrc = C_RES_DATA;
        w_regw        = 1'b1;
      end
      S_EXECUTER: bus.ALUSrcB = C_SRCB_REG;
      S_EXECUTEI: bus.ALUSrcB = C_SRCB_IMM;
      S_ALUWB:    w_regw      = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcB   = C_SRCB_IMM;
        bus.ResultSrc = C_RES_ALU;
        w_branch      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.RegW       = w_regw;
  assign bus.Branch     = w_branch;
  assign bus.PCS        = ((bus.Rd == 4'hF) & w_regw) | w_branch;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01) & ~bus.Funct[0], (bus.Op == 2'b10)};
  assign bus.ALUControl = w_alu_ctrl;
  assign bus.FlagW      = w_flag_w;
  assign bus.illegal    = w_illegal;
  assign bus.mem_err    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl_fsm
// Description : Self-checking bench for multicycle_ctrl_fsm. A reference
//               model expands each instruction into its expected sequence
//               of per-cycle controls from the instruction class and the
//               chosen memory wait counts; directed and random scenarios
//               are compared cycle by cycle.
//               Honours MULTICYCLE_CTRL_CMP_EN for the CMP expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam int TIMEOUT = 15;
  // phase tags used by the model
  localparam int P_F = 0, P_D = 1, P_A = 2, P_R = 3, P_M = 4;
  localparam int P_WB = 5, P_E = 6, P_W = 7, P_B = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [22:0] exp_q[$];
  bit          rdy_q[$];
  logic [11:0] in_q[$];
  logic [1:0]  cur_op;
  logic [5:0]  cur_fn;
  logic [3:0]  cur_rd;
  logic [3:0]  cmds [6] = '{4'b1101, 4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};

  multicycle_ctrl_fsm_if #(.ALUCTRL_W(3)) bus ();

  multicycle_ctrl_fsm #(
    .ALUCTRL_W (3),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic bit cmd_ok(logic [3:0] c);
    bit ok;
    ok = (c == 4'b1101) || (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100);
`ifdef MULTICYCLE_CTRL_CMP_EN
    if (c == 4'b1010) ok = 1'b1;
`endif
    return ok;
  endfunction

  function automatic logic [2:0] alu_code(logic [3:0] c);
    case (c)
      4'b1101: return 3'b100;
      4'b0010: return 3'b001;
      4'b0000: return 3'b010;
      4'b1100: return 3'b011;
      4'b1010: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for one cycle of a given phase
  function automatic logic [22:0] phase_out(int ph, bit rdy, bit err, logic [1:0] op,
                                            logic [5:0] fn, logic [3:0] rd);
    logic       irw, adr, srca, npc, regw, memw, br, pcs, ill;
    logic [1:0] srcb, res, flg, regsrc;
    logic [2:0] alu;
    {irw, adr, srca, npc, regw, memw, br, ill} = '0;
    srcb = '0; res = '0; flg = '0; alu = '0;
    case (ph)
      P_F:  begin srca = 1'b1; srcb = 2'b10; res = 2'b10; irw = rdy; npc = rdy; end
      P_D:  begin
        srca = 1'b1; srcb = 2'b10; res = 2'b10;
        ill = (op == 2'b11) || (op == 2'b00 && !cmd_ok(fn[4:1]));
      end
      P_A:  srcb = 2'b01;
      P_R:  adr = 1'b1;
      P_M:  begin adr = 1'b1; memw = !err; end
      P_WB: begin res = 2'b01; regw = 1'b1; end
      P_E:  begin
        srcb = fn[5] ? 2'b01 : 2'b00;
        alu  = alu_code(fn[4:1]);
        flg  = {fn[0], fn[0] && (alu == 3'b000 || alu == 3'b001)};
      end
      P_W:  regw = 1'b1;
      P_B:  begin srcb = 2'b01; res = 2'b10; br = 1'b1; end
      default: ;
    endcase
    pcs    = (rd == 4'hF && regw) || br;
    regsrc = {op == 2'b01 && !fn[0], op == 2'b10};
    return {irw, adr, srca, npc, regw, memw, br, pcs, srcb, res, op, regsrc, flg, alu, ill, err};
  endfunction

  function automatic logic [22:0] pack_out();
    return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
            bus.PCS, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.FlagW,
            bus.ALUControl, bus.illegal, bus.mem_err};
  endfunction

  task automatic clear_plan();
    exp_q.delete(); rdy_q.delete(); in_q.delete();
  endtask

  task automatic push(int ph, bit rdy, bit err);
    exp_q.push_back(phase_out(ph, rdy, err, cur_op, cur_fn, cur_rd));
    rdy_q.push_back(rdy);
    in_q.push_back({cur_op, cur_fn, cur_rd});
  endtask

  // A memory-facing phase: w stall cycles, then completion or abort
  task automatic mem_phase(int ph, int w, output bit ok);
    int n;
    n = (w > TIMEOUT) ? TIMEOUT : w;
    for (int k = 0; k < n; k++) push(ph, 1'b0, 1'b0);
    if (w <= TIMEOUT) begin push(ph, 1'b1, 1'b0); ok = 1'b1; end
    else              begin push(ph, 1'b0, 1'b1); ok = 1'b0; end
  endtask

  // Expand one instruction into its cycle sequence
  task automatic plan(logic [1:0] op, logic [5:0] fn, logic [3:0] rd, int wf, int wm);
    bit ok;
    cur_op = op; cur_fn = fn; cur_rd = rd;
    mem_phase(P_F, wf, ok);
    if (!ok) return;
    push(P_D, 1'($urandom_range(0, 1)), 1'b0);
    if (op == 2'b11 || (op == 2'b00 && !cmd_ok(fn[4:1]))) return;
    case (op)
      2'b00: begin
        push(P_E, 1'($urandom_range(0, 1)), 1'b0);
        if (fn[4:1] != 4'b1010) push(P_W, 1'($urandom_range(0, 1)), 1'b0);
      end
      2'b01: begin
        push(P_A, 1'($urandom_range(0, 1)), 1'b0);
        if (fn[0]) begin
          mem_phase(P_R, wm, ok);
          if (ok) push(P_WB, 1'($urandom_range(0, 1)), 1'b0);
        end else begin
          mem_phase(P_M, wm, ok);
        end
      end
      default: push(P_B, 1'($urandom_range(0, 1)), 1'b0);
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 0;
    if (r < 85) return $urandom_range(1, 4);
    if (r < 92) return TIMEOUT;
    return TIMEOUT + 1 + $urandom_range(0, 3);
  endfunction

  task automatic test_reset();
    bit          rdy;
    logic [11:0] in;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      in  = 12'($urandom);
      {bus.Op, bus.Funct, bus.Rd} = in;
      bus.mem_ready = rdy;
      #1;
      n_cmp++;
      if (pack_out() !== phase_out(P_F, rdy, 1'b0, in[11:10], in[9:4], in[3:0])) begin
        n_bad++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, pack_out(),
                 phase_out(P_F, rdy, 1'b0, in[11:10], in[9:4], in[3:0]));
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    clear_plan();
    plan(2'b00, 6'b001000, 4'd1, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL add cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  task automatic test_ldr_wait();
    clear_plan();
    plan(2'b01, 6'b011001, 4'd5, 0, 3);
    plan(2'b01, 6'b011001, 4'd6, 2, TIMEOUT);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL ldr_wait cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  task automatic test_str_timeout();
    int memw_cycles;
    clear_plan();
    plan(2'b01, 6'b011000, 4'd2, 0, TIMEOUT + 10);
    plan(2'b10, 6'b000000, 4'd0, 0, 0);
    plan(2'b00, 6'b101000, 4'd3, TIMEOUT + 1, 0);
    memw_cycles = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      if (bus.MemW === 1'b1) memw_cycles++;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL str_timeout cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
    n_cmp++;
    if (memw_cycles !== TIMEOUT) begin
      n_bad++;
      $display("FAIL str_memw_count: got %0d expected %0d", memw_cycles, TIMEOUT);
    end
  endtask

  task automatic test_subs_pc();
    clear_plan();
    plan(2'b00, 6'b000101, 4'hF, 0, 0);
    plan(2'b00, 6'b101001, 4'hF, 1, 0);
    plan(2'b00, 6'b011011, 4'd4, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL subs_pc cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal_cmp();
    clear_plan();
    plan(2'b11, 6'b000000, 4'd0, 0, 0);
    plan(2'b00, 6'b010101, 4'd0, 0, 0);
    plan(2'b00, 6'b110100, 4'hF, 0, 0);
    plan(2'b00, 6'b001110, 4'd1, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL illegal_cmp cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midway();
    clear_plan();
    plan(2'b01, 6'b011000, 4'd3, 0, 30);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midway_pre cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pack_out() !== phase_out(P_F, 1'b0, 1'b0, 2'b01, 6'b011000, 4'd3)) begin
      n_bad++;
      $display("FAIL midway_async: got %h expected %h", pack_out(),
               phase_out(P_F, 1'b0, 1'b0, 2'b01, 6'b011000, 4'd3));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    // a full fetch timeout afterwards proves the counter restarted from 0
    clear_plan();
    plan(2'b00, 6'b001000, 4'd1, TIMEOUT + 1, 0);
    plan(2'b10, 6'b000000, 4'd0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midway_post cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int         r;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    clear_plan();
    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      fn = 6'($urandom);
      if (op == 2'b00 && $urandom_range(0, 4) != 0) fn[4:1] = cmds[$urandom_range(0, 5)];
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      plan(op, fn, rd, rand_wait(), rand_wait());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      {bus.Op, bus.Funct, bus.Rd} = in_q[i];
      bus.mem_ready = rdy_q[i];
      #1;
      n_cmp++;
      if (pack_out() !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %h expected %h", i, pack_out(), exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.Op        = 2'b00;
    bus.Funct     = 6'b000000;
    bus.Rd        = 4'd0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_ldr_wait();
    test_str_timeout();
    test_subs_pc();
    test_illegal_cmp();
    test_reset_midway();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
